// File: rtl/instruction_set.sv
// Shared z8 memory-port types: command encodings, responder states and data-store defaults.
package instruction_set;

    localparam int unsigned DATA_MEM_SIZE     = 256;
    localparam int unsigned DMEM_READ_LATENCY = 1;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } MEM_OPS_T;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } DMEM_STATE_T;

    // Which source drives mem_rd_data after a read completes.
    typedef enum logic [1:0] {
        RD_SRC_ZERO  = 2'd0,
        RD_SRC_ARRAY = 2'd1,
        RD_SRC_IO    = 2'd2
    } rd_src_t;

endpackage

// File: rtl/dmem_array.sv
// Data store: one synchronous write port and one registered read port; contents survive reset.
module dmem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the z8 core: fixed-latency reads, range/overrun flags.
// Define DMEM_MMIO_EN to map address DATA_MEM_SIZE onto the io_out register.
module data_mem_responder
    import instruction_set::*;
#(
    parameter int unsigned DATA_MEM_SIZE = instruction_set::DATA_MEM_SIZE,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned READ_LATENCY  = instruction_set::DMEM_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  MEM_OPS_T              mem_op,
    input  logic [ADDR_WIDTH-1:0] mem_rw_addr,
    input  logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_rd_valid,
    output logic                  mem_busy,
    output logic                  mem_addr_err,
    output logic                  mem_overrun,
    input  logic                  mem_overrun_clr
`ifdef DMEM_MMIO_EN
    ,
    output logic [DATA_WIDTH-1:0] io_out
`endif
);

    localparam int unsigned IDX_W = (DATA_MEM_SIZE > 1) ? $clog2(DATA_MEM_SIZE) : 1;
    localparam int unsigned CNT_W = 2;
    localparam logic [ADDR_WIDTH-1:0] SIZE_A = ADDR_WIDTH'(DATA_MEM_SIZE);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("data_mem_responder: READ_LATENCY must be in 1..4");
        end
    endgenerate

    DMEM_STATE_T           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    rd_src_t               rd_src_q, rd_src_d;
    logic                  rd_valid_d, busy_d, addr_err_d, overrun_d;
    logic                  wr_en, rd_en, enter_resp;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic [DATA_WIDTH-1:0] arr_rd_data;
    logic                  is_read, is_write, is_cmd;
`ifdef DMEM_MMIO_EN
    logic [DATA_WIDTH-1:0] io_d, io_rd_q, io_rd_d;
`endif

    // Encodings outside the enum decode as neither read nor write.
    assign is_read  = (mem_op == MEM_READ);
    assign is_write = (mem_op == MEM_WRITE);
    assign is_cmd   = is_read | is_write;

    dmem_array #(
        .DEPTH (DATA_MEM_SIZE),
        .WIDTH (DATA_WIDTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (mem_rw_addr[IDX_W-1:0]),
        .wr_data (mem_wr_data),
        .rd_en   (rd_en),
        .rd_idx  (resp_addr[IDX_W-1:0]),
        .rd_data (arr_rd_data)
    );

    // Next-state, array strobes and next values for every registered output.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rd_src_d   = rd_src_q;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;
        overrun_d  = mem_overrun & ~mem_overrun_clr;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        enter_resp = 1'b0;
        resp_addr  = addr_q;
`ifdef DMEM_MMIO_EN
        io_d       = io_out;
        io_rd_d    = io_rd_q;
`endif
        case (state_q)
            IDLE: begin
                if (is_write) begin
                    if (mem_rw_addr < SIZE_A) begin
                        wr_en = 1'b1;
                    end
`ifdef DMEM_MMIO_EN
                    else if (mem_rw_addr == SIZE_A) begin
                        io_d = mem_wr_data;
                    end
`endif
                    else begin
                        addr_err_d = 1'b1;
                    end
                end else if (is_read) begin
                    addr_d = mem_rw_addr;
                    cnt_d  = CNT_W'(READ_LATENCY - 1);
                    if (READ_LATENCY == 1) begin
                        enter_resp = 1'b1;
                        resp_addr  = mem_rw_addr;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (is_cmd) begin
                    overrun_d = 1'b1;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (is_cmd) begin
                    overrun_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Resolve the read source on the edge that enters RESP.
        if (enter_resp) begin
            state_d    = RESP;
            rd_valid_d = 1'b1;
            if (resp_addr < SIZE_A) begin
                rd_en    = 1'b1;
                rd_src_d = RD_SRC_ARRAY;
            end
`ifdef DMEM_MMIO_EN
            else if (resp_addr == SIZE_A) begin
                rd_src_d = RD_SRC_IO;
                io_rd_d  = io_out;
            end
`endif
            else begin
                rd_src_d   = RD_SRC_ZERO;
                addr_err_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            rd_src_q     <= RD_SRC_ZERO;
            mem_rd_valid <= 1'b0;
            mem_busy     <= 1'b0;
            mem_addr_err <= 1'b0;
            mem_overrun  <= 1'b0;
`ifdef DMEM_MMIO_EN
            io_out       <= '0;
            io_rd_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            rd_src_q     <= rd_src_d;
            mem_rd_valid <= rd_valid_d;
            mem_busy     <= busy_d;
            mem_addr_err <= addr_err_d;
            mem_overrun  <= overrun_d;
`ifdef DMEM_MMIO_EN
            io_out       <= io_d;
            io_rd_q      <= io_rd_d;
`endif
        end
    end

    // Read data is a pure select among flops, so it holds between reads.
    always_comb begin
        case (rd_src_q)
            RD_SRC_ARRAY: mem_rd_data = arr_rd_data;
`ifdef DMEM_MMIO_EN
            RD_SRC_IO:    mem_rd_data = io_rd_q;
`endif
            default:      mem_rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder at READ_LATENCY=2 (DMEM_MMIO_EN aware).
module tb_data_mem_responder;
    import instruction_set::*;

    localparam int unsigned LAT = 2;
`ifdef DMEM_MMIO_EN
    localparam logic [15:0] OOR = 16'h0101;
`else
    localparam logic [15:0] OOR = 16'h0100;
`endif
    localparam logic [15:0] LO = OOR & 16'h00FF;
    localparam logic [1:0] N = 2'd0, R = 2'd1, W = 2'd2, X = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n;
    MEM_OPS_T    mem_op;
    logic [15:0] mem_rw_addr, mem_wr_data, mem_rd_data;
    logic        mem_rd_valid, mem_busy, mem_addr_err, mem_overrun, mem_overrun_clr;
`ifdef DMEM_MMIO_EN
    logic [15:0] io_out;
`endif

    data_mem_responder #(.DATA_MEM_SIZE(256), .DATA_WIDTH(16), .ADDR_WIDTH(16),
                         .READ_LATENCY(LAT)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_op          (mem_op),
        .mem_rw_addr     (mem_rw_addr),
        .mem_wr_data     (mem_wr_data),
        .mem_rd_data     (mem_rd_data),
        .mem_rd_valid    (mem_rd_valid),
        .mem_busy        (mem_busy),
        .mem_addr_err    (mem_addr_err),
        .mem_overrun     (mem_overrun),
        .mem_overrun_clr (mem_overrun_clr)
`ifdef DMEM_MMIO_EN
        ,
        .io_out          (io_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        clr;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_busy;
        logic        exp_err;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check16(input string name, input int row, input logic [15:0] act,
                           input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
    endtask

    task automatic check1(input string name, input int row, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (row %0d): got %b, expected %b", name, row, act, exp);
    endtask

    task automatic add(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic clr, input logic v, input logic [15:0] d, input logic b,
                       input logic e, input logic o);
        vecs.push_back('{op, addr, wdata, clr, v, d, b, e, o});
    endtask

    task automatic drive(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic clr);
        mem_op          = MEM_OPS_T'(op);
        mem_rw_addr     = addr;
        mem_wr_data     = wdata;
        mem_overrun_clr = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        logic got;
        int   lat;

        // op, addr, wdata, clr | valid, data, busy, err, overrun (after the edge)
        add(W, LO,      16'h1111, 0,  0, 16'h0000, 0, 0, 0);
        add(W, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 0);
        add(R, 16'h0010, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        add(N, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, 1, 0, 0);
        add(N, 16'h0000, 16'h0000, 0, 0, 16'hBEEF, 0, 0, 0);
        add(W, 16'h00FF, 16'h1234, 0, 0, 16'hBEEF, 0, 0, 0);
        add(R, 16'h00FF, 16'h0000, 0, 0, 16'hBEEF, 1, 0, 0);
        add(N, 16'h0000, 16'h0000, 0, 1, 16'h1234, 1, 0, 0);
        add(N, 16'h0000, 16'h0000, 0, 0, 16'h1234, 0, 0, 0);
        add(W, OOR,      16'hAAAA, 0, 0, 16'h1234, 0, 1, 0);
        add(N, 16'h0000, 16'h0000, 0, 0, 16'h1234, 0, 0, 0);
        add(R, OOR,      16'h0000, 0, 0, 16'h1234, 1, 0, 0);
        add(N, 16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 1, 0);
        add(N, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
        add(R, LO,       16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        add(N, 16'h0000, 16'h0000, 0, 1, 16'h1111, 1, 0, 0);
        add(N, 16'h0000, 16'h0000, 0, 0, 16'h1111, 0, 0, 0);
        add(R, 16'h1010, 16'h0000, 0, 0, 16'h1111, 1, 0, 0);
        add(N, 16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 1, 0);
        add(N, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
        add(R, 16'h0010, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
        add(W, 16'h0010, 16'h5555, 0, 1, 16'hBEEF, 1, 0, 1);
        add(N, 16'h0000, 16'h0000, 0, 0, 16'hBEEF, 0, 0, 1);
        add(X, 16'h0010, 16'h7777, 0, 0, 16'hBEEF, 0, 0, 1);
        add(R, 16'h0010, 16'h0000, 0, 0, 16'hBEEF, 1, 0, 1);
        add(N, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, 1, 0, 1);
        add(N, 16'h0000, 16'h0000, 1, 0, 16'hBEEF, 0, 0, 0);
        add(R, 16'h00FF, 16'h0000, 0, 0, 16'hBEEF, 1, 0, 0);
        add(N, 16'h0000, 16'h0000, 0, 1, 16'h1234, 1, 0, 0);
        add(W, 16'h00FF, 16'h9999, 1, 0, 16'h1234, 0, 0, 1);
        add(N, 16'h0000, 16'h0000, 1, 0, 16'h1234, 0, 0, 0);
        add(R, 16'h00FF, 16'h0000, 0, 0, 16'h1234, 1, 0, 0);
        add(N, 16'h0000, 16'h0000, 0, 1, 16'h1234, 1, 0, 0);
        add(N, 16'h0000, 16'h0000, 0, 0, 16'h1234, 0, 0, 0);

        reset_n = 1'b0;
        drive(N, 16'h0000, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check1("reset valid", -1, mem_rd_valid, 1'b0);
        check1("reset busy", -1, mem_busy, 1'b0);
        check1("reset addr_err", -1, mem_addr_err, 1'b0);
        check1("reset overrun", -1, mem_overrun, 1'b0);
        check16("reset rd_data", -1, mem_rd_data, 16'h0000);
`ifdef DMEM_MMIO_EN
        check16("reset io_out", -1, io_out, 16'h0000);
`endif
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].clr);
            step();
            check1("rd_valid", i, mem_rd_valid, vecs[i].exp_valid);
            check16("rd_data", i, mem_rd_data, vecs[i].exp_data);
            check1("busy", i, mem_busy, vecs[i].exp_busy);
            check1("addr_err", i, mem_addr_err, vecs[i].exp_err);
            check1("overrun", i, mem_overrun, vecs[i].exp_ovr);
        end
        drive(N, 16'h0000, 16'h0000, 1'b0);
        step();

        // Reset one cycle into a read: the read is abandoned, array survives.
        drive(R, 16'h0010, 16'h0000, 1'b0);
        step();
        drive(N, 16'h0000, 16'h0000, 1'b0);
        check1("busy before abort", 100, mem_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check1("abort valid", 100, mem_rd_valid, 1'b0);
        check1("abort busy", 100, mem_busy, 1'b0);
        check16("abort rd_data", 100, mem_rd_data, 16'h0000);
        step();
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            step();
            if (mem_rd_valid) seen = 1'b1;
        end
        check1("no valid after abort", 101, seen, 1'b0);

        drive(R, 16'h0010, 16'h0000, 1'b0);
        step();
        drive(N, 16'h0000, 16'h0000, 1'b0);
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 6 && !got; k++) begin
            step();
            if (mem_rd_valid) begin
                got = 1'b1;
                lat = k + 2;
            end
        end
        check1("post-reset read valid seen", 102, got, 1'b1);
        check16("post-reset read latency", 102, 16'(lat), 16'(LAT));
        check16("post-reset read data", 102, mem_rd_data, 16'hBEEF);
        step();

`ifdef DMEM_MMIO_EN
        drive(W, 16'h0100, 16'h00C3, 1'b0);
        step();
        drive(N, 16'h0000, 16'h0000, 1'b0);
        check16("mmio io_out", 200, io_out, 16'h00C3);
        check1("mmio write err", 200, mem_addr_err, 1'b0);
        drive(R, 16'h0100, 16'h0000, 1'b0);
        step();
        drive(N, 16'h0000, 16'h0000, 1'b0);
        step();
        check1("mmio read valid", 201, mem_rd_valid, 1'b1);
        check16("mmio read data", 201, mem_rd_data, 16'h00C3);
        check1("mmio read err", 201, mem_addr_err, 1'b0);
        step();
        drive(W, 16'h0101, 16'hDDDD, 1'b0);
        step();
        drive(N, 16'h0000, 16'h0000, 1'b0);
        check1("mmio+1 write err", 202, mem_addr_err, 1'b1);
        check16("mmio+1 io_out kept", 202, io_out, 16'h00C3);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the z8 core's data-memory port.
- Accepts one-cycle MEM_READ/MEM_WRITE commands with address and write data, and owns the DATA_MEM_SIZE-word data store.
- Returns read data with a valid pulse after a fixed latency, and flags out-of-range accesses and commands issued while busy.
- Sits between the control unit / register-file datapath and the storage array.

Parameters:
- DATA_MEM_SIZE, 256: number of 16-bit words; valid addresses are 0..DATA_MEM_SIZE-1.
- DATA_WIDTH, 16: word width.
- ADDR_WIDTH, 16: width of mem_rw_addr.
- READ_LATENCY, 1: cycles from read capture to mem_rd_valid; legal range 1..4, elaboration error otherwise.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_op  in  MEM_OPS_T  MEM_NOP / MEM_READ / MEM_WRITE; a non-NOP value is a command.
- mem_rw_addr  in  ADDR_WIDTH  word address, sampled with the command.
- mem_wr_data  in  DATA_WIDTH  write data, sampled with MEM_WRITE.
- mem_rd_data  out  DATA_WIDTH  read result; holds its value between reads.
- mem_rd_valid  out  1  one-cycle pulse when mem_rd_data carries a new read result.
- mem_busy  out  1  high while a read is in flight.
- mem_addr_err  out  1  one-cycle pulse on an out-of-range access.
- mem_overrun  out  1  sticky; set when a command arrives while busy.
- mem_overrun_clr  in  1  synchronous clear of mem_overrun.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, all outputs 0, latency counter 0.
  - Array contents are not reset.
  - Reset mid-read aborts the read; no valid pulse follows.
- States: IDLE, WAIT, RESP (DMEM_STATE_T).
- IDLE, mem_op=MEM_WRITE at edge t:
  - In range: array[addr] <= mem_wr_data on edge t. Stay IDLE; mem_busy stays 0.
  - Out of range (addr >= DATA_MEM_SIZE): write discarded; mem_addr_err=1 during cycle t+1.
- IDLE, mem_op=MEM_READ at edge t:
  - Latch the address. Counter <= READ_LATENCY-1.
  - Go to RESP if READ_LATENCY=1, else WAIT.
  - mem_busy=1 from cycle t+1.
- WAIT: counter decrements each cycle; when it reaches 1, go to RESP.
- RESP:
  - mem_rd_data=array[latched addr], mem_rd_valid=1 for exactly this cycle, which is cycle t+READ_LATENCY.
  - Next state IDLE; mem_busy drops in the following cycle.
  - Out-of-range read: mem_rd_data=0, valid pulse still occurs at normal latency, mem_addr_err pulses in the same cycle.
- Commands while state != IDLE are dropped (not queued): mem_overrun <= 1, no array change.
  - A command in the RESP cycle is also dropped.
- mem_overrun_clr=1 clears mem_overrun.
  - Simultaneous clr and a new overrun event: set wins.
- Read-after-write: a write at edge t followed by a read at edge t+1 to the same address returns the new data. No bypass is required because the write commits first.
- Address compare is a full ADDR_WIDTH unsigned compare; no wrap-around or truncation.
- mem_op encodings outside the enum are treated as MEM_NOP.

Optional Feature:
- Macro DMEM_MMIO_EN.
- Defined:
  - Adds output port io_out[DATA_WIDTH-1:0], reset 0.
  - Address DATA_MEM_SIZE becomes an I/O register: MEM_WRITE updates io_out on the capture edge; MEM_READ returns io_out with normal latency; no mem_addr_err.
  - Addresses > DATA_MEM_SIZE are still errors.
- Undefined: no io_out port; address DATA_MEM_SIZE is out of range like any other.

Decomposition:
- Package instruction_set holds MEM_OPS_T and DATA_MEM_SIZE already; add DMEM_STATE_T {IDLE, WAIT, RESP} and the READ_LATENCY default there.
- One sub-module, dmem_array: DATA_MEM_SIZE x DATA_WIDTH storage with one synchronous write port and one registered read port, no reset.
- The responder holds the FSM, counter, range check, error/overrun flags and MMIO logic.

Test Plan (DATA_MEM_SIZE=256, READ_LATENCY=2):
- Write/read: WRITE addr 0x0010 data 0xBEEF, then READ 0x0010 next cycle -> mem_rd_valid pulses 2 cycles after the read, mem_rd_data=0xBEEF, mem_busy high for those 2 cycles.
- Stack top: WRITE 0x00FF=0x1234, READ 0x00FF -> 0x1234, no mem_addr_err.
- Out of range: WRITE 0x0100=0xAAAA -> mem_addr_err pulse, array unchanged. READ 0x0100 -> mem_rd_data=0x0000, mem_rd_valid and mem_addr_err together at latency 2.
- Overrun: READ 0x0010 then WRITE 0x0010=0x5555 on the next cycle -> write dropped, mem_overrun=1, read still returns 0xBEEF. Pulse mem_overrun_clr -> mem_overrun=0.
- Reset mid-read: READ issued, reset_n low one cycle later -> mem_rd_valid never pulses, all outputs 0. After release, READ 0x0010 still returns 0xBEEF (array retained).
- With DMEM_MMIO_EN: WRITE 0x0100=0x00C3 -> io_out=0x00C3 next cycle, no error. READ 0x0100 -> 0x00C3. WRITE 0x0101 -> mem_addr_err.
